// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: accepts 1..8 beat read/write commands,
// streams write data through a one-entry holding register and returns read data.
module wb_burst_master #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            RESETN,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [2:0]      cmd_len,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    input  logic [DW/8-1:0] wsel,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            rd_last,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);
    localparam int SW  = DW / 8;
    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, END} state_t;

    state_t         state, state_nxt;
    logic [2:0]     beat_cnt;
    logic [2:0]     len_r;
    logic [3:0]     to_load;
    logic [WDW-1:0] wdog;

    logic busy, ack_eff, timeout, fault, last_ack, accept, load;

    // In write mode wb_stb_o doubles as the holding-register full flag.
    always_comb begin
        busy     = (state == WRITE) || (state == READ);
        ack_eff  = busy && wb_stb_o && wb_ack_i && !wb_err_i;
        timeout  = busy && wb_stb_o && !wb_ack_i && !wb_err_i && (wdog == WDW'(TIMEOUT - 1));
        fault    = busy && wb_stb_o && (wb_err_i || timeout);
        last_ack = ack_eff && (beat_cnt == len_r);
        accept   = cmd_valid && cmd_ready;
        wdat_ready = (state == WRITE) && (!wb_stb_o || ack_eff) && (to_load != 4'd0);
        load     = wdat_valid && wdat_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (accept) state_nxt = cmd_we ? WRITE : READ;
            WRITE, READ: if (fault || last_ack) state_nxt = END;
            default:     state_nxt = IDLE;
        endcase
    end

    assign wb_bte_o = 2'b00;

    always_ff @(posedge wb_clk_i or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_cti_o  <= 3'b000;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            beat_cnt  <= 3'd0;
            len_r     <= 3'd0;
            to_load   <= 4'd0;
            wdog      <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            done      <= 1'b0;
            err       <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            if (accept) begin
                wb_cyc_o  <= 1'b1;
                wb_stb_o  <= !cmd_we;
                wb_we_o   <= cmd_we;
                wb_addr_o <= cmd_addr;
                wb_dat_o  <= '0;
                wb_sel_o  <= cmd_we ? '0 : '1;
                wb_cti_o  <= (cmd_len == 3'd0) ? 3'b111 : 3'b010;
                len_r     <= cmd_len;
                beat_cnt  <= 3'd0;
                to_load   <= cmd_we ? ({1'b0, cmd_len} + 4'd1) : 4'd0;
                wdog      <= '0;
            end else if (busy) begin
                if (fault) begin
                    // Abort: drop the bus and flush anything still held.
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    wb_dat_o <= '0;
                    wb_sel_o <= '0;
                    to_load  <= 4'd0;
                    wdog     <= '0;
                    err      <= 1'b1;
                end else begin
                    if (ack_eff) begin
                        wb_addr_o <= wb_addr_o + AW'(SW);
                        beat_cnt  <= beat_cnt + 3'd1;
                        wb_cti_o  <= (3'(beat_cnt + 3'd1) == len_r) ? 3'b111 : 3'b010;
                        wdog      <= '0;
                    end else if (wb_stb_o) begin
                        wdog <= wdog + WDW'(1);
                    end
                    if (state == READ && ack_eff) begin
                        rd_data  <= wb_dat_i;
                        rd_valid <= 1'b1;
                        rd_last  <= last_ack;
                    end
                    if (last_ack) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        done     <= 1'b1;
                    end else if (state == WRITE) begin
                        // A load in the ack cycle refills the holding slot with no bubble.
                        if (load) begin
                            wb_dat_o <= wdat;
                            wb_sel_o <= wsel;
                            wb_stb_o <= 1'b1;
                            to_load  <= to_load - 4'd1;
                        end else if (ack_eff) begin
                            wb_stb_o <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: behavioural Wishbone slave, write-data source and
// per-burst reference model of addresses, cti, data and status pulses.
module tb_wb_burst_master;
    localparam int DW = 32;
    localparam int AW = 26;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [2:0]      cmd_len = '0;
    logic            wdat_valid = 1'b0, wdat_ready;
    logic [DW-1:0]   wdat = '0;
    logic [SW-1:0]   wsel = '0;
    logic            rd_valid, rd_last, done, err;
    logic [DW-1:0]   rd_data;
    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [SW-1:0]   wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [DW-1:0]   wb_dat_i = '0;
    logic            wb_ack_i = 1'b0, wb_err_i = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master #(.DW(DW), .AW(AW), .TIMEOUT(255)) dut (
        .wb_clk_i(clk), .RESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat), .wsel(wsel),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int n_tests = 0, n_fail = 0;

    // slave behaviour: 0 ack every stb cycle, 1 every other, 2 never, 3 random
    int ack_mode = 0, err_beat = -1;
    bit err_with_ack = 0, stray_ack = 0, tog = 0;
    int stall_mode = 0, stall = 0;

    logic [DW-1:0] wsrc_d[$], exp_wd[$], exp_rd[$], ob_dat[$], ob_rd[$];
    logic [SW-1:0] wsrc_s[$], exp_ws[$], ob_sel[$];
    logic [AW-1:0] ob_addr[$];
    logic [2:0]    ob_cti[$];
    logic          ob_we[$], ob_last[$];
    int cyc_n, stb_n, stb_rise, cyc_rise, done_n, err_n, addr_viol;
    logic prev_stb = 0, prev_cyc = 0, prev_ack = 0;
    logic [AW-1:0] prev_addr = '0;

    // Slave + monitor: respond to the current cycle and record what the bus shows.
    always @(negedge clk) begin
        logic ga, ge;
        ga = 0; ge = 0;
        cyc_n += int'(wb_cyc_o);
        stb_n += int'(wb_stb_o);
        if (wb_stb_o && !prev_stb) stb_rise++;
        if (wb_cyc_o && !prev_cyc) cyc_rise++;
        if (wb_stb_o && prev_stb && !prev_ack && wb_addr_o !== prev_addr) addr_viol++;
        done_n += int'(done);
        err_n  += int'(err);
        if (rd_valid) begin ob_rd.push_back(rd_data); ob_last.push_back(rd_last); end
        if (wb_stb_o) begin
            case (ack_mode)
                0: ga = 1;
                1: begin ga = tog; tog = !tog; end
                2: ga = 0;
                default: ga = ($urandom_range(0, 1) == 1);
            endcase
            if (ga && ob_addr.size() == err_beat) begin ge = 1; ga = err_with_ack; end
        end else if (stray_ack) ga = 1;
        wb_ack_i = ga; wb_err_i = ge; wb_dat_i = $urandom;
        if (wb_stb_o && ga && !ge) begin
            ob_addr.push_back(wb_addr_o); ob_cti.push_back(wb_cti_o); ob_we.push_back(wb_we_o);
            ob_dat.push_back(wb_dat_o); ob_sel.push_back(wb_sel_o);
            if (!wb_we_o) exp_rd.push_back(wb_dat_i);
        end
        prev_stb = wb_stb_o; prev_cyc = wb_cyc_o; prev_ack = ga || ge; prev_addr = wb_addr_o;
    end

    // Write-data source; in stall mode valid stays low 3 cycles after each transfer.
    always @(posedge clk) begin
        bit hs;
        hs = wdat_valid && wdat_ready;
        #1;
        if (hs) begin
            wsrc_d.delete(0); wsrc_s.delete(0);
            stall = (stall_mode != 0) ? 3 : 0;
        end else if (stall > 0) stall--;
        wdat_valid = (wsrc_d.size() > 0) && (stall == 0);
        wdat = (wsrc_d.size() > 0) ? wsrc_d[0] : '0;
        wsel = (wsrc_s.size() > 0) ? wsrc_s[0] : '0;
    end

    function automatic int beat_errs(input logic we, input logic [AW-1:0] a, input logic [2:0] len);
        int e = 0;
        int nb = int'(len) + 1;
        logic [AW-1:0] ea;
        if (ob_addr.size() != nb) return 1000;
        if (!we && ob_rd.size() != nb) return 1000;
        if (we && ob_rd.size() != 0) return 1000;
        for (int i = 0; i < nb; i++) begin
            ea = a + AW'(i * SW);
            if (ob_addr[i] !== ea) e++;
            if (ob_cti[i] !== ((i == nb - 1) ? 3'b111 : 3'b010)) e++;
            if (ob_we[i] !== we) e++;
            if (we) begin
                if (ob_dat[i] !== exp_wd[i] || ob_sel[i] !== exp_ws[i]) e++;
            end else begin
                if (ob_sel[i] !== {SW{1'b1}} || ob_rd[i] !== exp_rd[i] || ob_last[i] !== (i == nb - 1)) e++;
            end
        end
        return e;
    endfunction

    task automatic clear_obs();
        ob_addr.delete(); ob_cti.delete(); ob_we.delete(); ob_dat.delete(); ob_sel.delete();
        ob_rd.delete(); ob_last.delete(); exp_rd.delete(); exp_wd.delete(); exp_ws.delete();
        wsrc_d.delete(); wsrc_s.delete();
        cyc_n = 0; stb_n = 0; stb_rise = 0; cyc_rise = 0; done_n = 0; err_n = 0; addr_viol = 0;
        tog = 0; stall = 0;
    endtask

    task automatic start_cmd(input logic we, input logic [AW-1:0] a, input logic [2:0] len);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int n;
        @(posedge clk); #2;
        clear_obs();
        if (we) for (int i = 0; i <= int'(len); i++) begin
            d = $urandom; s = SW'($urandom_range(1, (1 << SW) - 1));
            wsrc_d.push_back(d); wsrc_s.push_back(s); exp_wd.push_back(d); exp_ws.push_back(s);
        end
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = len;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        n_tests++;
        if (n >= 50) begin n_fail++; $display("FAIL cmd_accept: cmd_ready got 0 want 1"); end
        @(posedge clk); #1 cmd_valid = 0;
    endtask

    task automatic run_cmd(input logic we, input logic [AW-1:0] a, input logic [2:0] len);
        int n;
        start_cmd(we, a, len);
        n = 0;
        while (done_n + err_n == 0 && n < 2000) begin @(negedge clk); n++; end
        n_tests++;
        if (n >= 2000) begin n_fail++; $display("FAIL burst_end: no done/err within %0d cycles", n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1; #2 rst_n = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, wdat_ready, rd_valid, rd_last, done, err} !== 9'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, wdat_ready, rd_valid, rd_last, done, err});
        end
        n_tests++;
        if ({wb_addr_o, wb_cti_o, wb_sel_o, wb_bte_o} !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 0", {wb_addr_o, wb_cti_o, wb_sel_o, wb_bte_o});
        end
        n_tests++;
        if ({wb_dat_o, rd_data} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {wb_dat_o, rd_data}); end
        rst_n = 1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_burst();
        ack_mode = 0;
        run_cmd(1, 26'h100, 3);
        n_tests++;
        if (beat_errs(1, 26'h100, 3) != 0) begin n_fail++; $display("FAIL wr4_beats: got %0d bad want 0", beat_errs(1, 26'h100, 3)); end
        n_tests++;
        if (ob_addr.size() == 4 && ob_addr[3] !== 26'h10C) begin n_fail++; $display("FAIL wr4_addr3: got %h want 10c", ob_addr[3]); end
        // one empty cycle while the first word loads, then 4 back-to-back beats
        n_tests++;
        if ({stb_rise, stb_n, cyc_n, done_n, err_n} !== {32'd1, 32'd4, 32'd5, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL wr4_shape: got rise=%0d stb=%0d cyc=%0d done=%0d err=%0d want 1 4 5 1 0", stb_rise, stb_n, cyc_n, done_n, err_n);
        end
    endtask

    task automatic test_read_stride();
        logic [AW-1:0] a;
        a = AW'($urandom) & ~AW'(SW - 1);
        ack_mode = 1;
        run_cmd(0, a, 7);
        n_tests++;
        if (beat_errs(0, a, 7) != 0) begin n_fail++; $display("FAIL rd8_beats: got %0d bad want 0", beat_errs(0, a, 7)); end
        n_tests++;
        if ({addr_viol, stb_n, cyc_n, done_n} !== {32'd0, 32'd16, 32'd16, 32'd1}) begin
            n_fail++; $display("FAIL rd8_shape: got viol=%0d stb=%0d cyc=%0d done=%0d want 0 16 16 1", addr_viol, stb_n, cyc_n, done_n);
        end
    endtask

    task automatic test_write_stall();
        ack_mode = 0; stall_mode = 1; stray_ack = 1;
        run_cmd(1, 26'h2000, 1);
        stall_mode = 0; stray_ack = 0;
        n_tests++;
        if (beat_errs(1, 26'h2000, 1) != 0) begin n_fail++; $display("FAIL stall_beats: got %0d bad want 0", beat_errs(1, 26'h2000, 1)); end
        // cyc low-stb cycles: initial load plus the 3 starved cycles
        n_tests++;
        if ({cyc_rise, stb_rise, cyc_n - stb_n, done_n} !== {32'd1, 32'd2, 32'd4, 32'd1}) begin
            n_fail++; $display("FAIL stall_shape: got cyc_rise=%0d stb_rise=%0d gap=%0d done=%0d want 1 2 4 1", cyc_rise, stb_rise, cyc_n - stb_n, done_n);
        end
    endtask

    task automatic test_timeout();
        ack_mode = 2;
        run_cmd(0, 26'h40, 3'($urandom_range(0, 7)));
        ack_mode = 0;
        n_tests++;
        if ({stb_n, cyc_n, err_n, done_n, ob_rd.size()} !== {32'd255, 32'd255, 32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL timeout: got stb=%0d cyc=%0d err=%0d done=%0d rd=%0d want 255 255 1 0 0", stb_n, cyc_n, err_n, done_n, ob_rd.size());
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a;
        a = '1; a = a - AW'(7);
        ack_mode = 0;
        run_cmd(0, a, 7);
        n_tests++;
        if (beat_errs(0, a, 7) != 0) begin n_fail++; $display("FAIL wrap_beats: got %0d bad want 0", beat_errs(0, a, 7)); end
        n_tests++;
        if (ob_addr.size() < 3 || ob_addr[2] !== '0) begin n_fail++; $display("FAIL wrap_zero: beat2 addr not 0 (n=%0d)", ob_addr.size()); end
    endtask

    task automatic test_error_recover();
        logic [AW-1:0] a;
        ack_mode = 0; err_beat = 1; err_with_ack = 1;
        run_cmd(1, 26'h300, 3);
        err_beat = -1; err_with_ack = 0;
        n_tests++;
        if ({err_n, done_n, ob_addr.size(), cyc_n} !== {32'd1, 32'd0, 32'd1, 32'd3}) begin
            n_fail++; $display("FAIL err_abort: got err=%0d done=%0d beats=%0d cyc=%0d want 1 0 1 3", err_n, done_n, ob_addr.size(), cyc_n);
        end
        a = AW'($urandom) & ~AW'(SW - 1);
        run_cmd(1, a, 2);
        n_tests++;
        if (beat_errs(1, a, 2) != 0 || done_n != 1 || err_n != 0) begin
            n_fail++; $display("FAIL err_next_cmd: got bad=%0d done=%0d err=%0d want 0 1 0", beat_errs(1, a, 2), done_n, err_n);
        end
    endtask

    task automatic test_reset_mid();
        ack_mode = 1;
        start_cmd(1, 26'h800, 7);
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, wdat_ready, done, err} !== 7'b0 || wb_addr_o !== '0 || wb_dat_o !== '0) begin
            n_fail++; $display("FAIL reset_mid: got ctl=%b addr=%h dat=%h want 0", {wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, wdat_ready, done, err}, wb_addr_o, wb_dat_o);
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 1", cmd_ready); end
        ack_mode = 0;
        run_cmd(1, 26'h900, 2);
        n_tests++;
        if (beat_errs(1, 26'h900, 2) != 0 || done_n != 1) begin
            n_fail++; $display("FAIL reset_mid_next: got bad=%0d done=%0d want 0 1", beat_errs(1, 26'h900, 2), done_n);
        end
    endtask

    task automatic test_random();
        logic          we;
        logic [AW-1:0] a;
        logic [2:0]    len;
        for (int k = 0; k < 20; k++) begin
            we = ($urandom_range(0, 1) == 1);
            a = AW'($urandom) & ~AW'(SW - 1);
            len = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2)) 0: ack_mode = 0; 1: ack_mode = 1; default: ack_mode = 3; endcase
            run_cmd(we, a, len);
            n_tests++;
            if (beat_errs(we, a, len) != 0 || done_n != 1 || err_n != 0) begin
                n_fail++; $display("FAIL random[%0d] we=%b len=%0d: got bad=%0d done=%0d err=%0d want 0 1 0", k, we, len, beat_errs(we, a, len), done_n, err_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_stride();
        test_write_stall();
        test_timeout();
        test_wrap();
        test_error_recover();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
